// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution accelerator: FSM states, mode decoding,
// tap-window bounds and the project arithmetic cells.
package conv_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StOut} conv_state_e;

  typedef logic [1:0] kernel_mode_t;
  typedef logic [1:0] stride_mode_t;

  function automatic int kernel_size(input kernel_mode_t mode);
    return 2 * int'(mode) + 1;
  endfunction

  function automatic int stride_size(input stride_mode_t mode);
    return 1 << int'(mode);
  endfunction

  // First in-map kernel offset for a window centred on pos.
  function automatic int tap_lo(input int pos, input int half);
    return (pos >= half) ? 0 : half - pos;
  endfunction

  // Last in-map kernel offset for a window centred on pos in a map of the given size.
  function automatic int tap_hi(input int pos, input int half, input int size);
    return (pos + half <= size - 1) ? 2 * half : size - 1 - pos + half;
  endfunction

  function automatic logic signed [63:0] mul_cell(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic signed [63:0] add_cell(input logic signed [63:0] a,
                                                  input logic signed [63:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate slice: signed product, wrapping accumulator with clear and enable.
module conv_mac
  import conv_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 arst_n_in,
  input  logic                                 clear,
  input  logic                                 en,
  input  logic signed [IO_DATA_WIDTH-1:0]      a,
  input  logic signed [IO_DATA_WIDTH-1:0]      b,
  output logic signed [ACCUMULATION_WIDTH-1:0] sum
);

  logic signed [ACCUMULATION_WIDTH-1:0] acc_q;
  logic signed [63:0]                   prod;

  always_comb begin
    prod = mul_cell(32'(a), 32'(b));
    sum  = ACCUMULATION_WIDTH'(add_cell(64'(acc_q), prod));
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/conv_top_system.sv
// Sequential 2-D convolution accelerator: layer FSM, loop counters and output formatting.
// Define CONV_SATURATE_EN to clamp results instead of truncating the accumulator.
module conv_top_system
  import conv_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 32,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16
) (
  input  logic                                    clk,
  input  logic                                    arst_n_in,
  input  logic [1:0]                              conv_kernel_mode,
  input  logic [1:0]                              conv_stride_mode,
  input  logic signed [IO_DATA_WIDTH-1:0]         a_input,
  input  logic                                    a_valid,
  output logic                                    a_ready,
  input  logic signed [IO_DATA_WIDTH-1:0]         b_input,
  input  logic                                    b_valid,
  output logic                                    b_ready,
  output logic signed [IO_DATA_WIDTH-1:0]         out,
  output logic                                    output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
  input  logic                                    start,
  output logic                                    running
);

  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW  = $clog2(OUTPUT_NB_CHANNELS);
  localparam int ICW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam int AW  = ACCUMULATION_WIDTH;

  localparam logic signed [AW-1:0] OutMax = {{(AW-IO_DATA_WIDTH+1){1'b0}},
                                             {(IO_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] OutMin = {{(AW-IO_DATA_WIDTH+1){1'b1}},
                                             {(IO_DATA_WIDTH-1){1'b0}}};

  if (EXT_MEM_HEIGHT < 1 || EXT_MEM_WIDTH < 1) begin : g_bad_ext_mem
    $error("external memory geometry must be non-zero");
  end

  conv_state_e   state_q;
  kernel_mode_t  kmode_q;
  stride_mode_t  smode_q;
  logic [XW-1:0] i_q;
  logic [YW-1:0] j_q;
  logic [CW-1:0] ch_q;
  logic [ICW-1:0] ic_q;
  logic [2:0]    kx_q, ky_q;
  logic          ready_q;

  logic                 fire, clear;
  logic signed [AW-1:0] acc_sum;
  logic signed [IO_DATA_WIDTH-1:0] out_fmt;
  int   half, stride, start_half, kx_lo, kx_hi, ky_hi, nxt_i, nxt_j;
  logic last_ic, last_kx, last_ky, last_ch, last_i, last_j;

  assign a_ready = ready_q;
  assign b_ready = ready_q;
  assign fire    = ready_q && a_valid && b_valid;
  assign clear   = (state_q == StOut) || (state_q == StIdle && start);

  conv_mac #(
    .IO_DATA_WIDTH      (IO_DATA_WIDTH),
    .ACCUMULATION_WIDTH (ACCUMULATION_WIDTH)
  ) u_mac (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear     (clear),
    .en        (fire),
    .a         (a_input),
    .b         (b_input),
    .sum       (acc_sum)
  );

  // The tap window is clipped to the map, so every MAC cycle is a real tap.
  always_comb begin
    half       = (kernel_size(kmode_q) - 1) / 2;
    stride     = stride_size(smode_q);
    start_half = (kernel_size(conv_kernel_mode) - 1) / 2;
    kx_lo      = tap_lo(stride * int'(i_q), half);
    kx_hi      = tap_hi(stride * int'(i_q), half, FEATURE_MAP_WIDTH);
    ky_hi      = tap_hi(stride * int'(j_q), half, FEATURE_MAP_HEIGHT);
    last_ic    = int'(ic_q) == INPUT_NB_CHANNELS - 1;
    last_kx    = int'(kx_q) == kx_hi;
    last_ky    = int'(ky_q) == ky_hi;
    last_ch    = int'(ch_q) == OUTPUT_NB_CHANNELS - 1;
    last_i     = int'(i_q) == (FEATURE_MAP_WIDTH + stride - 1) / stride - 1;
    last_j     = int'(j_q) == (FEATURE_MAP_HEIGHT + stride - 1) / stride - 1;
    nxt_i      = int'(i_q);
    nxt_j      = int'(j_q);
    if (last_ch) begin
      if (last_i) begin
        nxt_i = 0;
        nxt_j = int'(j_q) + 1;
      end else begin
        nxt_i = int'(i_q) + 1;
      end
    end
  end

  always_comb begin
`ifdef CONV_SATURATE_EN
    if (acc_sum > OutMax) begin
      out_fmt = OutMax[IO_DATA_WIDTH-1:0];
    end else if (acc_sum < OutMin) begin
      out_fmt = OutMin[IO_DATA_WIDTH-1:0];
    end else begin
      out_fmt = acc_sum[IO_DATA_WIDTH-1:0];
    end
`else
    out_fmt = acc_sum[IO_DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= StIdle;
      kmode_q      <= '0;
      smode_q      <= '0;
      i_q          <= '0;
      j_q          <= '0;
      ch_q         <= '0;
      ic_q         <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      ready_q      <= 1'b0;
      running      <= 1'b0;
      output_valid <= 1'b0;
      out          <= '0;
      output_x     <= '0;
      output_y     <= '0;
      output_ch    <= '0;
    end else begin
      output_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            kmode_q <= conv_kernel_mode;
            smode_q <= conv_stride_mode;
            i_q     <= '0;
            j_q     <= '0;
            ch_q    <= '0;
            ic_q    <= '0;
            kx_q    <= 3'(start_half);
            ky_q    <= 3'(start_half);
            ready_q <= 1'b1;
            running <= 1'b1;
            state_q <= StMac;
          end
        end
        StMac: begin
          if (fire) begin
            if (!last_ic) begin
              ic_q <= ic_q + ICW'(1);
            end else begin
              ic_q <= '0;
              if (!last_kx) begin
                kx_q <= kx_q + 3'd1;
              end else begin
                kx_q <= 3'(kx_lo);
                if (!last_ky) begin
                  ky_q <= ky_q + 3'd1;
                end else begin
                  state_q      <= StOut;
                  ready_q      <= 1'b0;
                  output_valid <= 1'b1;
                  out          <= out_fmt;
                  output_x     <= i_q;
                  output_y     <= j_q;
                  output_ch    <= ch_q;
                end
              end
            end
          end
        end
        StOut: begin
          if (last_ch) begin
            ch_q <= '0;
            if (last_i) begin
              i_q <= '0;
              j_q <= j_q + YW'(1);
            end else begin
              i_q <= i_q + XW'(1);
            end
          end else begin
            ch_q <= ch_q + CW'(1);
          end
          kx_q <= 3'(tap_lo(stride * nxt_i, half));
          ky_q <= 3'(tap_lo(stride * nxt_j, half));
          if (last_ch && last_i && last_j) begin
            state_q <= StIdle;
            running <= 1'b0;
          end else begin
            state_q <= StMac;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_top_system.sv
// Directed bench for conv_top_system on a reduced 8x8 map with 2 in / 2 out channels.
module tb_conv_top_system;

  localparam int Io   = 16;
  localparam int Acc  = 48;
  localparam int Fmw  = 8;
  localparam int Fmh  = 8;
  localparam int Ich  = 2;
  localparam int Och  = 2;

  typedef struct {
    int     x;
    int     y;
    int     ch;
    longint v;
  } res_t;

  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  logic [1:0] conv_kernel_mode = '0;
  logic [1:0] conv_stride_mode = '0;
  logic signed [Io-1:0] a_input = '0;
  logic signed [Io-1:0] b_input = '0;
  logic a_valid = 1'b0;
  logic b_valid = 1'b0;
  logic a_ready, b_ready, output_valid, running;
  logic start = 1'b0;
  logic signed [Io-1:0] out;
  logic [$clog2(Fmw)-1:0] output_x;
  logic [$clog2(Fmh)-1:0] output_y;
  logic [$clog2(Och)-1:0] output_ch;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t got_q[$];
  int   hs_cnt, run_cyc, rdy_bad;
  bit   stall_en = 1'b0;
  logic signed [Io-1:0] a_val = '0;
  logic signed [Io-1:0] b_val = '0;

  always #5 clk = ~clk;

  conv_top_system #(
    .IO_DATA_WIDTH      (Io),
    .ACCUMULATION_WIDTH (Acc),
    .EXT_MEM_HEIGHT     (32),
    .EXT_MEM_WIDTH      (32),
    .FEATURE_MAP_WIDTH  (Fmw),
    .FEATURE_MAP_HEIGHT (Fmh),
    .INPUT_NB_CHANNELS  (Ich),
    .OUTPUT_NB_CHANNELS (Och)
  ) dut (
    .clk              (clk),
    .arst_n_in        (arst_n_in),
    .conv_kernel_mode (conv_kernel_mode),
    .conv_stride_mode (conv_stride_mode),
    .a_input          (a_input),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .b_input          (b_input),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .out              (out),
    .output_valid     (output_valid),
    .output_x         (output_x),
    .output_y         (output_y),
    .output_ch        (output_ch),
    .start            (start),
    .running          (running)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor and valid driver; an invalid word carries 0 so a premature consume corrupts sums.
  always @(negedge clk) begin
    if (output_valid === 1'b1) begin
      got_q.push_back('{x: int'(output_x), y: int'(output_y), ch: int'(output_ch),
                        v: longint'(out)});
    end
    if (running === 1'b1) run_cyc++;
    if (a_ready !== b_ready) rdy_bad++;
    a_valid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    b_valid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    a_input = a_valid ? a_val : '0;
    b_input = b_valid ? b_val : '0;
  end

  always @(posedge clk) begin
    if (arst_n_in && a_ready && a_valid && b_valid) hs_cnt++;
  end

  function automatic longint fmt_out(input longint p);
    longint acc = (p <<< (64 - Acc)) >>> (64 - Acc);
    longint lo  = acc & 64'hFFFF;
`ifdef CONV_SATURATE_EN
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return acc;
`else
    if (lo >= 32768) lo -= 65536;
    return lo;
`endif
  endfunction

  task automatic run_layer(input string name, input int km, input int sm,
                           input int av, input int bv, input bit stall, input bit glitch);
    int k = 2 * km + 1;
    int h = km;
    int s = 1 << sm;
    int cyc = 0;
    int idx = 0;
    int exp_cyc = 0;
    int exp_hs = 0;
    got_q.delete();
    a_val = Io'(av);
    b_val = Io'(bv);
    stall_en = stall;
    @(negedge clk);
    hs_cnt = 0;
    run_cyc = 0;
    rdy_bad = 0;
    conv_kernel_mode = 2'(km);
    conv_stride_mode = 2'(sm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    conv_kernel_mode = 2'(3 - km);
    conv_stride_mode = 2'(3 - sm);
    check({name, "_run_rise"}, running, 1);
    while (running === 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
    end
    check({name, "_done"}, running, 0);
    stall_en = 1'b0;
    for (int j = 0; j < (Fmh + s - 1) / s; j++) begin
      for (int i = 0; i < (Fmw + s - 1) / s; i++) begin
        for (int ch = 0; ch < Och; ch++) begin
          int cnt = 0;
          for (int ky = 0; ky < k; ky++) begin
            for (int kx = 0; kx < k; kx++) begin
              int xx = s * i + kx - h;
              int yy = s * j + ky - h;
              if (xx >= 0 && xx < Fmw && yy >= 0 && yy < Fmh) cnt++;
            end
          end
          exp_cyc += cnt * Ich + 1;
          exp_hs  += cnt * Ich;
          if (idx < got_q.size()) begin
            check({name, "_xyc"}, got_q[idx].x * 10000 + got_q[idx].y * 100 + got_q[idx].ch,
                  i * 10000 + j * 100 + ch);
            check({name, "_val"}, got_q[idx].v,
                  fmt_out(longint'(av) * longint'(bv) * Ich * cnt));
          end
          idx++;
        end
      end
    end
    check({name, "_count"}, got_q.size(), idx);
    check({name, "_handshakes"}, hs_cnt, exp_hs);
    check({name, "_ready_eq"}, rdy_bad, 0);
    if (!stall) check({name, "_cycles"}, run_cyc, exp_cyc);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_valid", output_valid, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_out", out, 0);
    check("rst_x", output_x, 0);
    check("rst_y", output_y, 0);
    check("rst_ch", output_ch, 0);
    arst_n_in = 1'b1;

    // K=1,S=1: every output is 2*3*2.
    run_layer("k1s1", 0, 0, 2, 3, 1'b0, 1'b0);
    if (got_q.size() > 0) check("k1s1_first", got_q[0].v, 12);

    // K=3,S=4: 2x2 grid, corner window clipped to 2x2, interior full 3x3.
    run_layer("k3s4", 1, 2, 1, 1, 1'b0, 1'b0);
    if (got_q.size() > 6) begin
      check("k3s4_corner", got_q[0].v, 8);
      check("k3s4_interior", got_q[6].v, 18);
    end

    run_layer("stall", 1, 1, -3, 5, 1'b1, 1'b0);
    run_layer("glitch", 2, 2, 7, -2, 1'b0, 1'b1);

    // 32 full-scale taps at (0,0) with K=7,S=8.
    run_layer("ovf", 3, 3, 32767, 32767, 1'b0, 1'b0);
    if (got_q.size() > 0) begin
`ifdef CONV_SATURATE_EN
      check("ovf_sat", got_q[0].v, 32767);
`else
      check("ovf_wrap", got_q[0].v, 32);
`endif
    end

    // Abort a layer mid-MAC with a one-cycle reset pulse.
    a_val = 16'sd2;
    b_val = 16'sd3;
    @(negedge clk);
    conv_kernel_mode = 2'd0;
    conv_stride_mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    arst_n_in = 1'b0;
    #1;
    check("abort_running", running, 0);
    check("abort_valid", output_valid, 0);
    check("abort_ready", a_ready, 0);
    check("abort_out", out, 0);
    check("abort_x", output_x, 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_stays_idle", running, 0);
    run_layer("restart", 1, 1, 4, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
